spi_slave: RTL
==============

SPI_SLAVE -- requirements
Module: spi_slave

Interface
REQ-001 SHALL have parameter SYNC_STAGES, default 2, number of synchronizer flops on Sclk_i, Mosi_i and Ss_ni (legal values 2..3).
REQ-002 SHALL have one clock and an asynchronous, active-low reset: Clk_i input 1, system clock; Rst_ni input 1, async active-low reset.
REQ-003 Sclk_i input 1: SPI clock from master.
REQ-004 Mosi_i input 1: serial data from master.
REQ-005 Ss_ni input 1: slave select, active low.
REQ-006 Miso_o output 1: serial data to master.
REQ-007 Miso_oe_o output 1: MISO drive enable, high only while selected.
REQ-008 TxBuf_i input 8: next byte to transmit.
REQ-009 TxLoad_i input 1: one-cycle strobe that writes TxBuf_i into the TX holding register.
REQ-010 TxReady_o output 1: TX holding register empty.
REQ-011 Rcvd_o output 8: last complete received byte.
REQ-012 Ready_o output 1: one-cycle pulse when a new byte is in Rcvd_o.

Function
REQ-013 Protocol SHALL be SPI mode 0, MSB first, 8-bit frames:
- Mosi sampled on Sclk rising edge.
- Miso changes on Sclk falling edge.
REQ-014 Sclk_i, Mosi_i and Ss_ni SHALL pass through SYNC_STAGES flops; edges SHALL be detected on the synchronized signals; supported Sclk frequency SHALL be at most Clk_i/4.
REQ-015 FSM states SHALL be IDLE, LOAD and SHIFT:
- IDLE->LOAD on synchronized Ss_n falling.
- LOAD->SHIFT after one cycle.
- SHIFT->IDLE on synchronized Ss_n rising.
- Any state->IDLE on reset.
REQ-016 In LOAD, the TX shift register SHALL take the holding register if full (holding then marked empty), else 0xFF; Miso_o SHALL then present bit 7.
REQ-017 In SHIFT, each Sclk rising edge SHALL shift the synchronized Mosi into the RX shift register LSB and increment a 3-bit bit counter.
REQ-018 In SHIFT, each Sclk falling edge SHALL shift the TX register left so that Miso_o presents the next bit.
REQ-019 When the counter wraps 7->0, Rcvd_o SHALL update and Ready_o SHALL pulse high for exactly one Clk_i cycle.
REQ-020 Latency from the Clk_i edge that detects the 8th synchronized Sclk rise to Ready_o high SHALL be 1 cycle.
REQ-021 On the 8th Sclk falling edge, the TX register SHALL reload from the holding register (or 0xFF if empty) for back-to-back bytes without Ss_n deassertion.
REQ-022 If TxLoad_i coincides with a reload, the reload SHALL use the prior holding content; TxBuf_i SHALL be stored and the holding register SHALL remain full.
REQ-023 If the holding register is empty at a reload, the holding register SHALL stay empty.
REQ-024 If TxLoad_i is asserted while the holding register is full, the holding register SHALL be overwritten.
REQ-025 If Ss_n rises mid-byte, the partial byte SHALL be discarded: counter cleared, no Ready_o, Rcvd_o unchanged.
REQ-026 Miso_oe_o SHALL be high in LOAD and SHIFT and low in IDLE; Miso_o SHALL be 0 in IDLE.
REQ-027 TxReady_o SHALL equal NOT(holding full), combinationally from the holding-register state.

Reset
REQ-028 On Rst_ni low, asynchronously:
- FSM SHALL go to IDLE.
- Counter SHALL be 0; shift registers SHALL be 0x00.
- Holding register SHALL be empty and TxReady_o 1.
- Rcvd_o SHALL be 0x00; Ready_o, Miso_o and Miso_oe_o SHALL be 0.
- Synchronizer flops SHALL take Ss_n=1, Sclk=0, Mosi=0.
REQ-029 Reset mid-byte SHALL abort the frame with no Ready_o pulse; after release, the block SHALL wait for a fresh Ss_n falling edge.

Configuration
REQ-030 Macro SPI_SLAVE_OVERRUN_EN SHALL control overrun detection.
- When defined, add input RxAck_i (1 bit) and output Overrun_o (1 bit).
- An internal pending flag SHALL set on each Ready_o pulse and clear on RxAck_i.
- If a byte completes while pending is set, Overrun_o SHALL be set sticky and Rcvd_o SHALL still update.
- Overrun_o and pending SHALL clear on RxAck_i or reset.
- If RxAck_i coincides with a byte completion, pending SHALL remain set and no overrun SHALL be flagged.
REQ-031 When SPI_SLAVE_OVERRUN_EN is undefined, the RxAck_i and Overrun_o ports and their logic SHALL be absent, with all other behaviour identical.

Verification
REQ-032 Load 0xA5, drop Ss_n, master sends 0x3C -> Mosi-side Rcvd_o=0x3C with one Ready_o pulse; master receives 0xA5.
REQ-033 Load 0x11, then 0x22 during byte 1, two back-to-back bytes -> master receives 0x11 then 0x22; TxReady_o returns high after each reload.
REQ-034 No TxLoad_i, one byte sent -> master receives 0xFF; TxReady_o stays 1.
REQ-035 Ss_n raised after 5 Sclk edges of 0xF0, then a full 0x81 sent -> only one Ready_o pulse, Rcvd_o=0x81.
REQ-036 Rst_ni pulsed low after 4 bits -> all outputs at reset values immediately; the next full frame 0x5A is received correctly.
REQ-037 With SPI_SLAVE_OVERRUN_EN defined, two bytes 0x01 and 0x02 with no RxAck_i -> Overrun_o=1 and Rcvd_o=0x02; RxAck_i clears Overrun_o.

Source files
------------

// File: rtl/spi_slave_if.sv
// ----------------------------------------------------------------------------
// spi_slave_if
// Bundles the SPI pins and the local TX/RX byte handshake of spi_slave.
//
// Signals:
//   Sclk_i, Mosi_i, Ss_ni  SPI clock, data-in and active-low select from master
//   Miso_o, Miso_oe_o      serial data to master and its drive enable
//   TxBuf_i, TxLoad_i      byte written into the TX holding register on strobe
//   TxReady_o              TX holding register empty
//   Rcvd_o, Ready_o        last received byte and its one-cycle valid pulse
//   RxAck_i, Overrun_o     only with SPI_SLAVE_OVERRUN_EN defined
//
// Modports: slave (the spi_slave view), master (the environment driving it).
// ----------------------------------------------------------------------------
interface spi_slave_if;
    logic       Sclk_i;
    logic       Mosi_i;
    logic       Ss_ni;
    logic       Miso_o;
    logic       Miso_oe_o;
    logic [7:0] TxBuf_i;
    logic       TxLoad_i;
    logic       TxReady_o;
    logic [7:0] Rcvd_o;
    logic       Ready_o;
`ifdef SPI_SLAVE_OVERRUN_EN
    logic       RxAck_i;
    logic       Overrun_o;
`endif

    modport slave (
        input  Sclk_i, Mosi_i, Ss_ni, TxBuf_i, TxLoad_i,
`ifdef SPI_SLAVE_OVERRUN_EN
        input  RxAck_i,
        output Overrun_o,
`endif
        output Miso_o, Miso_oe_o, TxReady_o, Rcvd_o, Ready_o
    );

    modport master (
        output Sclk_i, Mosi_i, Ss_ni, TxBuf_i, TxLoad_i,
`ifdef SPI_SLAVE_OVERRUN_EN
        output RxAck_i,
        input  Overrun_o,
`endif
        input  Miso_o, Miso_oe_o, TxReady_o, Rcvd_o, Ready_o
    );
endinterface

// File: rtl/spi_slave.sv
// ----------------------------------------------------------------------------
// spi_slave
// SPI mode-0 slave, MSB first, 8-bit frames, oversampled by the system clock.
// Sclk/Mosi/Ss_n are synchronized into Clk_i and edges are detected on the
// synchronized copies, so Sclk must stay at or below Clk_i/4.
//
// Ports:
//   Clk_i   system clock
//   Rst_ni  asynchronous active-low reset
//   bus     spi_slave_if.slave (SPI pins plus TX holding / RX byte handshake)
//
// Parameter:
//   SYNC_STAGES  synchronizer depth on Sclk, Mosi and Ss_n (2 or 3)
//
// Optional feature: define SPI_SLAVE_OVERRUN_EN to add RxAck_i/Overrun_o
// overrun detection on the received-byte path.
// ----------------------------------------------------------------------------
module spi_slave #(
    parameter int unsigned SYNC_STAGES = 2
) (
    input logic         Clk_i,
    input logic         Rst_ni,
    spi_slave_if.slave  bus
);

    typedef enum logic [1:0] {
        StIdle,
        StLoad,
        StShift
    } spiState_t;

    spiState_t stateQ, stateD;

    logic [SYNC_STAGES-1:0] sclkSyncQ, mosiSyncQ, ssSyncQ;
    logic                   sclkPrevQ, ssPrevQ;
    logic                   sclkS, mosiS, ssS;
    logic                   sclkRise, sclkFall, ssFall, ssRise;

    logic [2:0] bitCntQ;
    logic [7:0] rxShiftQ;
    logic [7:0] txShiftQ;
    logic [7:0] holdQ;
    logic       holdFullQ;
    logic [7:0] rcvdQ;
    logic       readyQ;

    logic loadTx;
    logic rxStep, txStep;
    logic byteDone, reload, takeHold;

    // ------------------------------------------------------------------------
    // Synchronizers and edge detection
    // ------------------------------------------------------------------------
    always_ff @(posedge Clk_i or negedge Rst_ni) begin
        if (!Rst_ni) begin
            sclkSyncQ <= '0;
            mosiSyncQ <= '0;
            ssSyncQ   <= '1;
            sclkPrevQ <= 1'b0;
            ssPrevQ   <= 1'b1;
        end else begin
            sclkSyncQ <= {sclkSyncQ[SYNC_STAGES-2:0], bus.Sclk_i};
            mosiSyncQ <= {mosiSyncQ[SYNC_STAGES-2:0], bus.Mosi_i};
            ssSyncQ   <= {ssSyncQ[SYNC_STAGES-2:0], bus.Ss_ni};
            sclkPrevQ <= sclkS;
            ssPrevQ   <= ssS;
        end
    end

    assign sclkS    = sclkSyncQ[SYNC_STAGES-1];
    assign mosiS    = mosiSyncQ[SYNC_STAGES-1];
    assign ssS      = ssSyncQ[SYNC_STAGES-1];
    assign sclkRise = sclkS & ~sclkPrevQ;
    assign sclkFall = ~sclkS & sclkPrevQ;
    assign ssFall   = ~ssS & ssPrevQ;
    assign ssRise   = ssS & ~ssPrevQ;

    // ------------------------------------------------------------------------
    // FSM
    // ------------------------------------------------------------------------
    always_ff @(posedge Clk_i or negedge Rst_ni) begin
        if (!Rst_ni) begin
            stateQ <= StIdle;
        end else begin
            stateQ <= stateD;
        end
    end

    always_comb begin
        stateD = stateQ;
        loadTx = 1'b0;
        unique case (stateQ)
            StIdle: begin
                if (ssFall) begin
                    stateD = StLoad;
                end
            end
            StLoad: begin
                loadTx = 1'b1;
                // A deselect arriving during the load cycle must not be lost.
                stateD = ssRise ? StIdle : StShift;
            end
            StShift: begin
                if (ssRise) begin
                    stateD = StIdle;
                end
            end
            default: stateD = StIdle;
        endcase
    end

    // A deselect takes priority over a coincident Sclk edge: the byte is dropped.
    assign rxStep   = (stateQ == StShift) & sclkRise & ~ssRise;
    assign txStep   = (stateQ == StShift) & sclkFall & ~ssRise;
    assign byteDone = rxStep & (bitCntQ == 3'd7);
    // In mode 0 the first Sclk edge of a frame is a rise, so a fall seen with
    // the counter at 0 can only be the 8th fall of a completed byte.
    assign reload   = txStep & (bitCntQ == 3'd0);
    assign takeHold = loadTx | reload;

    // ------------------------------------------------------------------------
    // Datapath
    // ------------------------------------------------------------------------
    always_ff @(posedge Clk_i or negedge Rst_ni) begin
        if (!Rst_ni) begin
            bitCntQ   <= 3'd0;
            rxShiftQ  <= 8'h00;
            txShiftQ  <= 8'h00;
            holdQ     <= 8'h00;
            holdFullQ <= 1'b0;
            rcvdQ     <= 8'h00;
            readyQ    <= 1'b0;
        end else begin
            readyQ <= byteDone;

            if (stateQ != StShift || ssRise) begin
                bitCntQ <= 3'd0;
            end else if (rxStep) begin
                bitCntQ <= bitCntQ + 3'd1;
            end

            if (rxStep) begin
                rxShiftQ <= {rxShiftQ[6:0], mosiS};
            end

            if (byteDone) begin
                rcvdQ <= {rxShiftQ[6:0], mosiS};
            end

            if (takeHold) begin
                txShiftQ <= holdFullQ ? holdQ : 8'hFF;
            end else if (txStep) begin
                txShiftQ <= {txShiftQ[6:0], 1'b0};
            end

            // A load coinciding with a reload wins: the reload already used the
            // old content, and the new byte keeps the register full.
            if (bus.TxLoad_i) begin
                holdQ     <= bus.TxBuf_i;
                holdFullQ <= 1'b1;
            end else if (takeHold) begin
                holdFullQ <= 1'b0;
            end
        end
    end

    assign bus.Miso_o    = (stateQ != StIdle) & txShiftQ[7];
    assign bus.Miso_oe_o = (stateQ != StIdle);
    assign bus.TxReady_o = ~holdFullQ;
    assign bus.Rcvd_o    = rcvdQ;
    assign bus.Ready_o   = readyQ;

`ifdef SPI_SLAVE_OVERRUN_EN
    // ------------------------------------------------------------------------
    // Overrun detection
    // ------------------------------------------------------------------------
    logic pendingQ, overrunQ;

    always_ff @(posedge Clk_i or negedge Rst_ni) begin
        if (!Rst_ni) begin
            pendingQ <= 1'b0;
            overrunQ <= 1'b0;
        end else begin
            if (byteDone) begin
                pendingQ <= 1'b1;
            end else if (bus.RxAck_i) begin
                pendingQ <= 1'b0;
            end

            // An ack in the completion cycle counts as reading the older byte.
            if (bus.RxAck_i) begin
                overrunQ <= 1'b0;
            end else if (byteDone && pendingQ) begin
                overrunQ <= 1'b1;
            end
        end
    end

    assign bus.Overrun_o = overrunQ;
`endif

endmodule
